// File: rtl/fwr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwr_pkg : shared constants and state type for the frame window reader     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fwr_pkg;
    localparam int FRAME_WIDTH   = 800;
    localparam int FRAME_HEIGHT  = 600;
    localparam int WORDS_PER_ROW = FRAME_WIDTH / 4;
    localparam int ADDR_W        = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fwr_state_t;
endpackage
`default_nettype wire

// File: rtl/fwr_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwr_word_fifo : synchronous FIFO holding returned SRAM words (DEPTH >= 2) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fwr_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // A push on full is accepted only alongside a pop; a pop on empty is dropped.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign rdata = mem[rptr[PW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/frame_window_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_window_reader : reads a rectangular window of an 8-bit grey frame   |
// | from word SRAM and streams it in raster order. FWR_CLIP_EN clamps the     |
// | window to the frame.                                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_window_reader #(
    parameter int                          FRAME_WIDTH  = fwr_pkg::FRAME_WIDTH,
    parameter int                          FRAME_HEIGHT = fwr_pkg::FRAME_HEIGHT,
    parameter logic [fwr_pkg::ADDR_W-1:0]  BASE_ADDR    = 18'd0,
    parameter int                          FIFO_DEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       start_ack,
    output logic                       done,
    input  logic                       done_ack,
    input  logic [9:0]                 win_x,
    input  logic [9:0]                 win_w,
    input  logic [9:0]                 win_y,
    input  logic [9:0]                 win_h,
    output logic [fwr_pkg::ADDR_W-1:0] addr,
    output logic                       addr_valid,
    input  logic                       addr_ready,
    input  logic [31:0]                data,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic [7:0]                 pixel,
    output logic                       pixel_valid,
    input  logic                       pixel_ready
);
    import fwr_pkg::*;

    localparam int ROW_WORDS = FRAME_WIDTH / 4;
    localparam int CW        = $clog2(FIFO_DEPTH + 1);

    fwr_state_t        state;
    fwr_state_t        state_nxt;
    logic [7:0]        n_cols;
    logic [9:0]        n_rows;
    logic              zero_win;
    logic [ADDR_W-1:0] start_base;
    logic [7:0]        cols_r;
    logic [7:0]        col_idx;
    logic [9:0]        rows_left;
    logic [ADDR_W-1:0] row_base;
    logic [CW-1:0]     credits;
    logic [CW-1:0]     credits_nxt;
    logic [1:0]        byte_idx;
    logic [31:0]       fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              issue;
    logic              pix_fire;
    logic              word_release;
    logic              accept_start;
    logic              addrs_left;
    logic              load_addr;
    logic              unused_bits;

    assign unused_bits = ^{win_x[1:0], win_w[1:0]};

`ifdef FWR_CLIP_EN
    logic [8:0]  col_lim;
    logic [10:0] row_lim;
    assign col_lim = 9'(ROW_WORDS) - {1'b0, win_x[9:2]};
    assign row_lim = 11'(FRAME_HEIGHT) - {1'b0, win_y};
`endif

    always_comb begin
        n_cols = win_w[9:2];
        n_rows = win_h;
`ifdef FWR_CLIP_EN
        if (({1'b0, win_x[9:2]} >= 9'(ROW_WORDS)) || ({1'b0, win_y} >= 11'(FRAME_HEIGHT))) begin
            n_cols = '0;
            n_rows = '0;
        end else begin
            if ({1'b0, win_w[9:2]} > col_lim) n_cols = col_lim[7:0];
            if ({1'b0, win_h} > row_lim)      n_rows = row_lim[9:0];
        end
`endif
    end

    assign zero_win   = (n_cols == '0) || (n_rows == '0);
    assign start_base = BASE_ADDR + ADDR_W'(32'(win_y) * ROW_WORDS) + ADDR_W'(win_x[9:2]);

    assign issue        = addr_valid && addr_ready;
    assign pix_fire     = pixel_valid && pixel_ready;
    assign word_release = pix_fire && (byte_idx == 2'd3);
    assign accept_start = (state == ST_IDLE) && start && !start_ack;
    assign addrs_left   = (rows_left != '0);
    assign credits_nxt  = credits - CW'(issue) + CW'(word_release);
    // Next address may be presented in the same cycle the previous one is taken.
    assign load_addr    = (state == ST_RUN) && addrs_left && (!addr_valid || issue)
                          && (credits_nxt != '0);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept_start) state_nxt = zero_win ? ST_DONE : ST_RUN;
            ST_RUN:   if (issue && !addrs_left) state_nxt = ST_DRAIN;
            ST_DRAIN: if (word_release && (credits_nxt == CW'(FIFO_DEPTH))) state_nxt = ST_DONE;
            ST_DONE:  if (done_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_ack  <= 1'b0;
            done       <= 1'b0;
            addr_valid <= 1'b0;
            addr       <= '0;
            credits    <= CW'(FIFO_DEPTH);
            byte_idx   <= 2'd0;
            cols_r     <= '0;
            col_idx    <= '0;
            rows_left  <= '0;
            row_base   <= '0;
        end else begin
            if (accept_start) start_ack <= 1'b1;
            else if (!start)  start_ack <= 1'b0;
            done    <= (state_nxt == ST_DONE);
            credits <= credits_nxt;
            if (pix_fire) byte_idx <= byte_idx + 2'd1;

            if (accept_start) begin
                cols_r    <= n_cols;
                rows_left <= zero_win ? 10'd0 : n_rows;
                col_idx   <= '0;
                row_base  <= start_base;
            end else if (load_addr) begin
                addr_valid <= 1'b1;
                addr       <= row_base + ADDR_W'(col_idx);
                if (col_idx == cols_r - 8'd1) begin
                    col_idx   <= '0;
                    row_base  <= row_base + ADDR_W'(ROW_WORDS);
                    rows_left <= rows_left - 10'd1;
                end else begin
                    col_idx <= col_idx + 8'd1;
                end
            end else if (issue) begin
                addr_valid <= 1'b0;
            end
        end
    end

    fwr_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (data_valid && data_ready),
        .wdata (data),
        .pop   (word_release),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign data_ready  = !fifo_full;
    assign pixel_valid = !fifo_empty;

    always_comb begin
        pixel = 8'h00;
        if (!fifo_empty) begin
            case (byte_idx)
                2'd0:    pixel = fifo_rdata[7:0];
                2'd1:    pixel = fifo_rdata[15:8];
                2'd2:    pixel = fifo_rdata[23:16];
                default: pixel = fifo_rdata[31:24];
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_frame_window_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_window_reader : directed self-checking bench with SRAM model     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_frame_window_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done_ack = 1'b0;
    logic [9:0]  win_x = '0, win_w = '0, win_y = '0, win_h = '0;
    logic        addr_ready = 1'b1;
    logic [31:0] data = '0;
    logic        data_valid = 1'b0;
    logic        pixel_ready = 1'b1;
    logic        start_ack, done, addr_valid, data_ready, pixel_valid;
    logic [17:0] addr;
    logic [7:0]  pixel;

    frame_window_reader dut (
        .clock(clock), .reset(reset), .start(start), .start_ack(start_ack),
        .done(done), .done_ack(done_ack),
        .win_x(win_x), .win_w(win_w), .win_y(win_y), .win_h(win_h),
        .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .data(data), .data_valid(data_valid), .data_ready(data_ready),
        .pixel(pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [17:0] a; int due; } req_t;
    req_t        memq[$];
    logic [17:0] addr_obs[$];
    logic [7:0]  pix_obs[$];
    logic [17:0] exp_a[$];
    logic [7:0]  exp_p[$];
    int  cyc = 0, lat = 1;
    bit  rnd_ready = 0;
    int  max_out, stall_cnt, av_cycles, done_pix;
    bit  done_seen;

    // SRAM model and output monitor; events recorded here take effect at the next edge.
    initial forever begin
        req_t r;
        int   outst;
        @(posedge clock); #1;
        cyc++;
        if (reset) begin
            memq.delete();
            data_valid = 1'b0;
        end else begin
            pixel_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            data_valid  = (memq.size() > 0) && (memq[0].due <= cyc);
            if (data_valid) data = {14'd0, memq[0].a};
            if (data_valid && !data_ready) stall_cnt++;
            if (data_valid && data_ready) void'(memq.pop_front());
            if (done && !done_seen) begin
                done_seen = 1;
                done_pix  = pix_obs.size();
            end
            if (addr_valid) av_cycles++;
            if (addr_valid && addr_ready) begin
                r.a = addr; r.due = cyc + lat;
                memq.push_back(r);
                addr_obs.push_back(addr);
            end
            if (pixel_valid && pixel_ready) pix_obs.push_back(pixel);
            outst = addr_obs.size() - pix_obs.size() / 4;
            if (outst > max_out) max_out = outst;
        end
    end

    task automatic clear_obs();
        memq.delete(); addr_obs.delete(); pix_obs.delete();
        max_out = 0; stall_cnt = 0; av_cycles = 0; done_seen = 0; done_pix = -1;
    endtask

    task automatic add_word(input logic [17:0] a);
        logic [31:0] w32;
        w32 = {14'd0, a};
        exp_a.push_back(a);
        for (int k = 0; k < 4; k++) exp_p.push_back(w32[8*k +: 8]);
    endtask

    task automatic do_start(input logic [9:0] x, y, w, h);
        int n;
        clear_obs();
        win_x = x; win_y = y; win_w = w; win_h = h;
        @(negedge clock); start = 1'b1;
        n = 0; while (!start_ack && n < 100) begin @(negedge clock); n++; end
        check("start_ack_rise", start_ack, 1);
        start = 1'b0;
        n = 0; while (start_ack && n < 100) begin @(negedge clock); n++; end
        check("start_ack_fall", start_ack, 0);
    endtask

    task automatic run_window(input logic [9:0] x, y, w, h, input int hold);
        int n;
        do_start(x, y, w, h);
        n = 0; while (!done && n < 5000) begin @(negedge clock); n++; end
        check("done_rise", done, 1);
        repeat (hold) @(negedge clock);
        check("done_hold", done, 1);
        done_ack = 1'b1;
        n = 0; while (done && n < 100) begin @(negedge clock); n++; end
        check("done_fall", done, 0);
        done_ack = 1'b0;
        @(negedge clock);
    endtask

    task automatic check_stream(input string name);
        check({name, ":n_addr"}, addr_obs.size(), exp_a.size());
        check({name, ":n_pix"}, pix_obs.size(), exp_p.size());
        check({name, ":pix_at_done"}, done_pix, exp_p.size());
        check({name, ":data_stall"}, stall_cnt, 0);
        for (int i = 0; i < addr_obs.size() && i < exp_a.size(); i++)
            check($sformatf("%s:addr[%0d]", name, i), addr_obs[i], exp_a[i]);
        for (int i = 0; i < pix_obs.size() && i < exp_p.size(); i++)
            check($sformatf("%s:pix[%0d]", name, i), pix_obs[i], exp_p[i]);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":start_ack"}, start_ack, 0);
        check({name, ":done"}, done, 0);
        check({name, ":addr_valid"}, addr_valid, 0);
        check({name, ":pixel_valid"}, pixel_valid, 0);
        check({name, ":data_ready"}, data_ready, 1);
        check({name, ":addr"}, addr, 0);
        check({name, ":pixel"}, pixel, 0);
    endtask

    task automatic set_basic_exp();
        exp_a = '{18'd0, 18'd1, 18'd200, 18'd201};
        exp_p = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                  8'hC8, 8'h00, 8'h00, 8'h00, 8'hC9, 8'h00, 8'h00, 8'h00};
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // 8x2 window, one-cycle SRAM, sink always ready
        lat = 1; rnd_ready = 0;
        run_window(10'd0, 10'd0, 10'd8, 10'd2, 0);
        set_basic_exp();
        check_stream("basic");
        check("basic:max_out_ok", max_out <= 4, 1);

        // 32x2 window, ten-cycle SRAM: credit limit reached, never exceeded
        lat = 10;
        run_window(10'd0, 10'd0, 10'd32, 10'd2, 0);
        exp_a.delete(); exp_p.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++) add_word(18'(r * 200 + c));
        check_stream("slow");
        check("slow:max_out", max_out, 4);

        // Sink back-pressure
        lat = 1; rnd_ready = 1;
        run_window(10'd0, 10'd0, 10'd8, 10'd2, 0);
        set_basic_exp();
        check_stream("rndready");
        rnd_ready = 0;

        // Bottom-right corner of the frame
`ifdef FWR_CLIP_EN
        run_window(10'd792, 10'd599, 10'd16, 10'd4, 0);
`else
        run_window(10'd792, 10'd599, 10'd8, 10'd1, 0);
`endif
        exp_a = '{18'd119998, 18'd119999};
        exp_p = '{8'hBE, 8'hD4, 8'h01, 8'h00, 8'hBF, 8'hD4, 8'h01, 8'h00};
        check_stream("corner");

        // Zero-width window: done without any address, held until acknowledged
        run_window(10'd0, 10'd0, 10'd0, 10'd2, 20);
        exp_a.delete(); exp_p.delete();
        check_stream("zero");
        check("zero:addr_valid_cycles", av_cycles, 0);

        // Reset mid-window after the third address is taken
        lat = 10;
        do_start(10'd0, 10'd0, 10'd32, 10'd2);
        n = 0; while (addr_obs.size() < 3 && n < 1000) begin @(negedge clock); n++; end
        check("midreset:three_addrs", addr_obs.size(), 3);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midreset");
        reset = 1'b0;
        @(negedge clock);
        lat = 1;
        run_window(10'd0, 10'd0, 10'd8, 10'd2, 0);
        set_basic_exp();
        check_stream("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
